bcd_scan_display: RTL

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

---
 rtl/bcd_scan_display.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed BCD display scanner with frame-synchronous (tear-free) value updates.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits 5..1.
module bcd_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        LOAD,
  input  logic [23:0] D,
  output logic [6:0]  SEG,
  output logic [5:0]  DIG,
  output logic        ERR
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [23:0]   disp;
  logic [23:0]   pend;
  logic          pend_v;
  logic          tick;
  logic          frame;
  logic [3:0]    nib;
  logic          err_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign tick  = (cnt == CW'(SCAN_DIV - 1));
  assign frame = tick && (idx == 3'd0);

  always_comb begin
    nib = 4'd0;
    case (idx)
      3'd0:    nib = disp[3:0];
      3'd1:    nib = disp[7:4];
      3'd2:    nib = disp[11:8];
      3'd3:    nib = disp[15:12];
      3'd4:    nib = disp[19:16];
      3'd5:    nib = disp[23:20];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    err_next = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (disp[4*i +: 4] > 4'd9) err_next = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] blank;
  logic       zero_above;

  // A digit blanks only if it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    blank      = 6'd0;
    zero_above = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  always_comb begin
    seg_next = seg7(nib);
    if (idx <= 3'd5 && blank[idx]) seg_next = 7'h00;
  end
`else
  always_comb begin
    seg_next = seg7(nib);
  end
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt    <= '0;
      idx    <= 3'd5;
      disp   <= 24'd0;
      pend   <= 24'd0;
      pend_v <= 1'b0;
      SEG    <= 7'h00;
      DIG    <= 6'd0;
      ERR    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == 3'd0) ? 3'd5 : idx - 3'd1;

      // The display register only ever changes at a frame boundary, so a frame never tears.
      if (frame) begin
        if (LOAD) begin
          disp   <= D;
          pend_v <= 1'b0;
        end else if (pend_v) begin
          disp   <= pend;
          pend_v <= 1'b0;
        end
      end else if (LOAD) begin
        pend   <= D;
        pend_v <= 1'b1;
      end

      SEG <= seg_next;
      DIG <= 6'd1 << idx;
      ERR <= err_next;
    end
  end

endmodule
